// File: rtl/draw_arbiter.sv
// ============================================================================
// Module  : draw_arbiter
// Purpose : Round-robin arbiter for two single-pixel writers plus a
//           full-screen fill sweep, driving a registered frame-buffer port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module draw_arbiter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fill_req,
    input  logic [2:0] fill_colour,
    output logic       fill_busy,
    output logic       fill_done,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [6:0] y0,
    input  logic [6:0] y1,
    input  logic [2:0] c0,
    input  logic [2:0] c1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    localparam logic [7:0] c_X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] c_Y_LAST = 7'(SCREEN_H - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_pref1;
    logic [7:0] r_fx;
    logic [6:0] r_fy;
    logic [2:0] r_fill_col;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_colour;
    logic       r_plot;

    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_xfer0;
    logic       w_xfer1;
    logic       w_in0;
    logic       w_in1;
    logic       w_last;
    logic [7:0] w_fx_nxt;
    logic [6:0] w_fy_nxt;

    assign w_in0   = (32'(x0) < SCREEN_W) && (32'(y0) < SCREEN_H);
    assign w_in1   = (32'(x1) < SCREEN_W) && (32'(y1) < SCREEN_H);
    assign w_xfer0 = req0 && w_gnt0;
    assign w_xfer1 = req1 && w_gnt1;
    assign w_last  = (r_fx == c_X_LAST) && (r_fy == c_Y_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_fx_nxt    = r_fx;
        w_fy_nxt    = r_fy;
        case (r_state)
            IDLE: begin
                if (!rst && fill_req) begin
                    w_state_nxt = FILL;
                end else if (!rst) begin
                    // Contention goes to whoever did not win last.
                    if (req0 && req1) begin
                        w_gnt0 = !r_pref1;
                        w_gnt1 = r_pref1;
                    end else begin
                        w_gnt0 = req0;
                        w_gnt1 = req1;
                    end
                end
            end
            FILL: begin
                if (w_last) begin
                    w_state_nxt = IDLE;
                end else if (r_fx == c_X_LAST) begin
                    w_fx_nxt = 8'd0;
                    w_fy_nxt = r_fy + 7'd1;
                end else begin
                    w_fx_nxt = r_fx + 8'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pref1    <= 1'b0;
            r_fx       <= 8'd0;
            r_fy       <= 7'd0;
            r_fill_col <= 3'd0;
            r_x        <= 8'd0;
            r_y        <= 7'd0;
            r_colour   <= 3'd0;
            r_plot     <= 1'b0;
        end else if (r_state == IDLE) begin
            if (fill_req) begin
                r_fill_col <= fill_colour;
                r_fx       <= 8'd0;
                r_fy       <= 7'd0;
                r_x        <= 8'd0;
                r_y        <= 7'd0;
                r_colour   <= fill_colour;
                r_plot     <= 1'b1;
            end else if (w_xfer0) begin
                r_pref1 <= 1'b1;
                r_plot  <= w_in0;
                if (w_in0) begin
                    r_x      <= x0;
                    r_y      <= y0;
                    r_colour <= c0;
                end
            end else if (w_xfer1) begin
                r_pref1 <= 1'b0;
                r_plot  <= w_in1;
                if (w_in1) begin
                    r_x      <= x1;
                    r_y      <= y1;
                    r_colour <= c1;
                end
            end else begin
                r_plot <= 1'b0;
            end
        end else begin
            // The counters always hold the pixel currently on the write port.
            r_fx     <= w_fx_nxt;
            r_fy     <= w_fy_nxt;
            r_x      <= w_fx_nxt;
            r_y      <= w_fy_nxt;
            r_colour <= r_fill_col;
            r_plot   <= !w_last;
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign x         = r_x;
    assign y         = r_y;
    assign colour    = r_colour;
    assign plot      = r_plot;
    assign fill_busy = (r_state == FILL);
    assign fill_done = (r_state == FILL) && w_last;

endmodule

`default_nettype wire

// File: tb/tb_draw_arbiter.sv
// ============================================================================
// Module  : tb_draw_arbiter
// Purpose : Randomized and directed bench for draw_arbiter against a
//           pixel-index reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_draw_arbiter;

    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fill_req = 1'b0;
    logic [2:0] fill_colour = 3'd0;
    logic       fill_busy, fill_done;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] x0 = 8'd0, x1 = 8'd0;
    logic [6:0] y0 = 7'd0, y1 = 7'd0;
    logic [2:0] c0 = 3'd0, c1 = 3'd0;
    logic       gnt0, gnt1;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    int n_checks = 0;
    int n_fail   = 0;

    draw_arbiter #(.SCREEN_W(W), .SCREEN_H(H)) dut (
        .clk(clk), .rst(rst),
        .fill_req(fill_req), .fill_colour(fill_colour),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .req0(req0), .req1(req1),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .c0(c0), .c1(c1),
        .gnt0(gnt0), .gnt1(gnt1),
        .x(x), .y(y), .colour(colour), .plot(plot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: fill progress is a plain pixel index, raster position
    // is derived from it arithmetically.
    bit m_fill = 0;
    int m_idx = 0;
    int m_fcol = 0;
    bit m_pref1 = 0;
    int e_plot = 0, e_x = 0, e_y = 0, e_col = 0;

    always @(negedge clk) begin
        int eg0, eg1;
        if (rst) begin
            chk("rst_gnt0", gnt0, 0);
            chk("rst_gnt1", gnt1, 0);
            chk("rst_plot", plot, 0);
            chk("rst_xyc", {x, y, colour}, 0);
            chk("rst_flags", {fill_busy, fill_done}, 0);
            m_fill = 0; m_idx = 0; m_pref1 = 0;
            e_plot = 0; e_x = 0; e_y = 0; e_col = 0;
        end else begin
            eg0 = 0; eg1 = 0;
            if (!m_fill && !fill_req) begin
                if (req0 && req1) begin
                    eg0 = !m_pref1; eg1 = m_pref1;
                end else begin
                    eg0 = req0; eg1 = req1;
                end
            end
            chk("gnt0", gnt0, eg0);
            chk("gnt1", gnt1, eg1);
            chk("plot", plot, e_plot);
            chk("fill_busy", fill_busy, m_fill);
            chk("fill_done", fill_done, (m_fill && m_idx == N - 1) ? 1 : 0);
            if (e_plot != 0) begin
                chk("x", x, e_x);
                chk("y", y, e_y);
                chk("colour", colour, e_col);
            end
            if (m_fill) begin
                if (m_idx == N - 1) begin
                    m_fill = 0; e_plot = 0;
                end else begin
                    m_idx++;
                    e_plot = 1; e_x = m_idx % W; e_y = m_idx / W; e_col = m_fcol;
                end
            end else if (fill_req) begin
                m_fill = 1; m_idx = 0; m_fcol = fill_colour;
                e_plot = 1; e_x = 0; e_y = 0; e_col = fill_colour;
            end else if (eg0 != 0) begin
                m_pref1 = 1;
                e_plot = (x0 < W && y0 < H) ? 1 : 0;
                if (e_plot != 0) begin e_x = x0; e_y = y0; e_col = c0; end
            end else if (eg1 != 0) begin
                m_pref1 = 0;
                e_plot = (x1 < W && y1 < H) ? 1 : 0;
                if (e_plot != 0) begin e_x = x1; e_y = y1; e_col = c1; end
            end else begin
                e_plot = 0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; fill_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int exp_g0 [4] = '{1, 0, 1, 0};
        int cnt;
        bit done_seen;
        bit t0, t1;

        // Reset release and a lone requester
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        req0 = 1'b1; x0 = 8'd5; y0 = 7'd7; c0 = 3'd3;
        @(negedge clk);
        chk("lone_gnt0", gnt0, 1);
        chk("lone_gnt1", gnt1, 0);
        @(posedge clk); #1 req0 = 1'b0;
        @(negedge clk);
        chk("lone_plot", plot, 1);
        chk("lone_x", x, 5);
        chk("lone_y", y, 7);
        chk("lone_col", colour, 3);

        // Contention alternates starting with requester 0
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        x0 = 8'd1; y0 = 7'd1; c0 = 3'd1; x1 = 8'd2; y1 = 7'd2; c1 = 3'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_gnt0", gnt0, exp_g0[i]);
            chk("rr_gnt1", gnt1, 1 - exp_g0[i]);
            if (i > 0) chk("rr_plot", plot, 1);
            @(posedge clk); #1;
            if (exp_g0[i] != 0) begin x0 = x0 + 8'd10; y0 = y0 + 7'd3; end
            else begin x1 = x1 + 8'd10; y1 = y1 + 7'd5; end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("rr_plot_last", plot, 1);

        // Off-screen pixel is consumed without a write
        @(posedge clk); #1;
        req0 = 1'b1; x0 = 8'd160; y0 = 7'd0; c0 = 3'd1;
        @(negedge clk);
        chk("oob_gnt0", gnt0, 1);
        @(posedge clk); #1;
        x0 = 8'd20; y0 = 7'd3; c0 = 3'd6;
        @(negedge clk);
        chk("oob_plot", plot, 0);
        @(posedge clk); #1 req0 = 1'b0;
        @(negedge clk);
        chk("after_oob_plot", plot, 1);
        chk("after_oob_x", x, 20);

        // Random pixel traffic, requests held until granted
        t0 = 0; t1 = 0;
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            t0 = req0 && gnt0;
            t1 = req1 && gnt1;
            @(posedge clk); #1;
            if (t0 || !req0) begin
                req0 = ($urandom_range(0, 3) != 0);
                x0 = 8'($urandom_range(0, 170)); y0 = 7'($urandom_range(0, 127));
                c0 = 3'($urandom);
            end
            if (t1 || !req1) begin
                req1 = ($urandom_range(0, 3) != 0);
                x1 = 8'($urandom_range(0, 170)); y1 = 7'($urandom_range(0, 127));
                c1 = 3'($urandom);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(posedge clk);

        // Full fill with requester 1 waiting throughout
        #1;
        fill_req = 1'b1; fill_colour = 3'd4;
        req1 = 1'b1; x1 = 8'd10; y1 = 7'd20; c1 = 3'd2;
        cnt = 0; done_seen = 0;
        for (int k = 0; k < 20000 && !done_seen; k++) begin
            @(negedge clk);
            if (k == 0) chk("fill_accept_gnt1", gnt1, 0);
            if (plot) begin
                if (cnt == 0) chk("fill_first_xy", {x, y}, 0);
                cnt++;
            end
            if (fill_done) begin
                done_seen = 1;
                chk("fill_last_x", x, 159);
                chk("fill_last_y", y, 119);
                chk("fill_last_col", colour, 4);
            end
        end
        chk("fill_done_seen", done_seen, 1);
        chk("fill_len", cnt, 19200);
        @(posedge clk); #1 fill_req = 1'b0;
        @(negedge clk);
        chk("post_fill_gnt1", gnt1, 1);
        chk("post_fill_busy", fill_busy, 0);
        @(posedge clk); #1 req1 = 1'b0;
        @(negedge clk);
        chk("post_fill_plot", plot, 1);
        chk("post_fill_x", x, 10);
        chk("post_fill_y", y, 20);

        // Fill aborted by reset at pixel 500
        @(posedge clk); #1;
        fill_req = 1'b1; fill_colour = 3'd5;
        @(posedge clk); #1 fill_req = 1'b0;
        cnt = 0;
        for (int k = 0; k < 1000 && cnt < 501; k++) begin
            @(negedge clk);
            if (plot) cnt++;
        end
        chk("abort_reached_500", cnt, 501);
        #1 rst = 1'b1;
        #1;
        chk("async_plot", plot, 0);
        chk("async_busy", fill_busy, 0);
        chk("async_done", fill_done, 0);
        chk("async_xyc", {x, y, colour}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("abort_idle_plot", plot, 0);
            chk("abort_idle_done", fill_done, 0);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter SCREEN_W, 160, screen width in pixels; legal x = 0..SCREEN_W-1.
REQ-002 Parameter SCREEN_H, 120, screen height in pixels; legal y = 0..SCREEN_H-1.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 fill_req  in  1  level request for a full-screen fill.
REQ-006 fill_colour  in  3  fill colour; latched when the fill is accepted.
REQ-007 fill_busy  out  1  high while the fill sweep is in progress.
REQ-008 fill_done  out  1  one-cycle pulse coincident with the final fill pixel.
REQ-009 req0, req1  in  1 each  single-pixel draw requests, held until granted.
REQ-010 x0, x1  in  8 each; y0, y1  in  7 each; c0, c1  in  3 each  pixel coordinates and colour per requester.
REQ-011 gnt0, gnt1  out  1 each  combinational grant; pixel transfers on a rising edge where req_i && gnt_i.
REQ-012 x  out  8; y  out  7; colour  out  3; plot  out  1  registered write port to the VGA frame buffer.

Function
REQ-013 States: IDLE (serves pixel requests) and FILL (sweeps the screen).
REQ-014 In IDLE, fill_req has absolute priority; when fill_req=1, gnt0=gnt1=0 and the next edge enters FILL, latches fill_colour and sets the sweep counters to x=0, y=0.
REQ-015 In IDLE with fill_req=0, exactly one of gnt0/gnt1 is high when any req is high; both low when neither req is high.
REQ-016 Round robin: req0 and req1 both high means grant the requester not granted last; a lone requester is granted every cycle.
REQ-017 Round-robin pointer resets to favour requester 0 first and updates only on an actual transfer.
REQ-018 A transfer at edge N drives plot=1 with that requester's x, y and colour during cycle N+1; one pixel per cycle, no bubbles under back-to-back requests.
REQ-019 A transferred pixel with x >= SCREEN_W or y >= SCREEN_H is consumed (granted) but produces plot=0.
REQ-020 With no transfer and not in FILL, plot=0; x, y and colour hold their last values.
REQ-021 In FILL, one pixel per cycle: plot=1, colour = latched fill colour, x increments 0..SCREEN_W-1, then wraps to 0 with y+1, raster order.
REQ-022 First fill pixel (0,0) is output in the cycle after acceptance; last pixel (SCREEN_W-1, SCREEN_H-1) is output SCREEN_W*SCREEN_H-1 cycles later (19199 at defaults).
REQ-023 fill_done=1 only in the cycle the last fill pixel is output; the following edge returns to IDLE.
REQ-024 fill_busy=1 from the cycle the first fill pixel is output through the cycle the last one is output.
REQ-025 In FILL, gnt0=gnt1=0; the fill cannot be pre-empted, and fill_req and fill_colour changes are ignored.
REQ-026 fill_req still high in the first IDLE cycle after a fill starts a new fill at the next edge; requesters drop fill_req on fill_done.
REQ-027 Sweep counters are wide enough for SCREEN_W*SCREEN_H with no overflow; x and y never exceed the screen bounds during FILL.

Reset
REQ-028 On rst=1, immediately and independent of clk: state=IDLE, plot=0, x=0, y=0, colour=0, fill_busy=0, fill_done=0, sweep counters=0, round-robin pointer favours requester 0.
REQ-029 Reset asserted mid-fill aborts the sweep without a fill_done pulse; after release, no fill resumes unless fill_req is high.
REQ-030 gnt0=gnt1=0 while rst=1.

Verification
REQ-031 Reset release, req0=1 (x0=5, y0=7, c0=3), req1=0 -> gnt0=1; next cycle plot=1, x=5, y=7, colour=3.
REQ-032 req0 and req1 held high for 4 cycles -> grants alternate 0,1,0,1; plot high for 4 consecutive cycles with matching coordinates.
REQ-033 fill_req=1, fill_colour=4 for one cycle in IDLE -> 19200 consecutive plot=1 cycles with colour=4 covering (0,0)..(159,119) in raster order; fill_done only on (159,119); then IDLE.
REQ-034 req1 held high during a fill -> gnt1=0 throughout; granted in the first IDLE cycle after fill_done.
REQ-035 Pixel request x0=160, y0=0 -> gnt0=1, next cycle plot=0; the following in-range request plots normally.
REQ-036 rst pulsed at fill pixel 500 -> all outputs 0 immediately, no fill_done; with fill_req low after release, plot stays 0.
